// File: rtl/fp_log2_seq_if.sv
//------------------------------------------------------------------------------
// fp_log2_seq_if : request/result bundle for the sequential FP32 log2 unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fp_log2_seq_if;
  logic        i_start;
  logic [31:0] i_operand;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_invalid;
  logic        o_divbyzero;

  modport master (
    output i_start, i_operand,
    input  o_busy, o_done, o_result, o_invalid, o_divbyzero
  );

  modport slave (
    input  i_start, i_operand,
    output o_busy, o_done, o_result, o_invalid, o_divbyzero
  );
endinterface

`default_nettype wire

// File: rtl/fp_log2_seq.sv
//------------------------------------------------------------------------------
// fp_log2_seq : FP32 log2 by repeated squaring of the significand, one
//               fraction bit per cycle, truncating normalisation to FP32.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_log2_seq #(
  parameter int FRAC_BITS = 23,
  parameter int MW        = 32
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fp_log2_seq_if.slave  bus
);

  localparam int VW = 9 + FRAC_BITS;
  localparam int PW = $clog2(VW);
  localparam int CW = $clog2(FRAC_BITS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ITER    = 3'd1,
    S_NORM    = 3'd2,
    S_SPECIAL = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_e;
  logic [MW-1:0]        r_m;
  logic [FRAC_BITS-1:0] r_frac;
  logic [CW-1:0]        r_cnt;
  logic [31:0]          r_sp_res;
  logic                 r_sp_inv;
  logic                 r_sp_dbz;
  logic                 r_busy;
  logic                 r_done;
  logic [31:0]          r_result;
  logic                 r_inv;
  logic                 r_dbz;

  // Operand classification, priority NaN > negative > zero/denormal > +inf
  logic [7:0]  w_opexp;
  logic [22:0] w_opman;
  logic        w_special;
  logic [31:0] w_sp_res;
  logic        w_sp_inv;
  logic        w_sp_dbz;

  assign w_opexp = bus.i_operand[30:23];
  assign w_opman = bus.i_operand[22:0];

  always_comb begin
    w_special = 1'b1;
    w_sp_res  = 32'h0000_0000;
    w_sp_inv  = 1'b0;
    w_sp_dbz  = 1'b0;
    if (w_opexp == 8'hFF && w_opman != 23'd0) begin
      w_sp_res = 32'h7FC0_0000;
      w_sp_inv = 1'b1;
    end else if (bus.i_operand[31] && bus.i_operand[30:0] != 31'd0) begin
      w_sp_res = 32'h7FC0_0000;
      w_sp_inv = 1'b1;
    end else if (w_opexp == 8'h00) begin
      w_sp_res = 32'hFF80_0000;
      w_sp_dbz = 1'b1;
    end else if (w_opexp == 8'hFF) begin
      w_sp_res = 32'h7F80_0000;
    end else begin
      w_special = 1'b0;
    end
  end

  // Squaring step on 2.(MW-2) fixed point; product realigned and truncated
  logic [2*MW-1:0] w_sq;
  logic [MW-1:0]   w_mt;
  logic            w_ge2;
  logic [MW-1:0]   w_mnext;

  assign w_sq    = r_m * r_m;
  assign w_mt    = MW'(w_sq >> (MW - 2));
  assign w_ge2   = w_mt[MW-1];
  assign w_mnext = w_ge2 ? (w_mt >> 1) : w_mt;

  // Fixed-point log2 value: unbiased exponent concatenated with fraction bits
  logic [VW-1:0]    w_v;
  logic [VW-1:0]    w_mag;
  logic [PW-1:0]    w_p;
  logic [VW+22:0]   w_ext;
  logic [22:0]      w_mant;
  logic [7:0]       w_expo;
  logic [31:0]      w_norm_res;

  assign w_v   = {9'({1'b0, r_e} - 9'd127), r_frac};
  assign w_mag = w_v[VW-1] ? (~w_v + VW'(1)) : w_v;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < VW; i++) begin
      if (w_mag[i]) w_p = PW'(i);
    end
  end

  assign w_ext      = {w_mag, 23'd0} << (VW - 1 - int'(w_p));
  assign w_mant     = 23'(w_ext >> (VW - 1));
  assign w_expo     = 8'(127 + int'(w_p) - FRAC_BITS);
  assign w_norm_res = (w_v == '0) ? 32'h0000_0000 : {w_v[VW-1], w_expo, w_mant};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.i_start) w_next = w_special ? S_SPECIAL : S_ITER;
      S_ITER:    if (r_cnt == CW'(FRAC_BITS - 1)) w_next = S_NORM;
      S_NORM:    w_next = S_DONE;
      S_SPECIAL: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e      <= '0;
      r_m      <= '0;
      r_frac   <= '0;
      r_cnt    <= '0;
      r_sp_res <= '0;
      r_sp_inv <= 1'b0;
      r_sp_dbz <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_inv    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      if (r_state == S_IDLE && bus.i_start) begin
        r_e      <= w_opexp;
        r_m      <= MW'({2'b01, w_opman}) << (MW - 25);
        r_frac   <= '0;
        r_cnt    <= '0;
        r_sp_res <= w_sp_res;
        r_sp_inv <= w_sp_inv;
        r_sp_dbz <= w_sp_dbz;
      end
      if (r_state == S_ITER) begin
        r_m    <= w_mnext;
        r_frac <= {r_frac[FRAC_BITS-2:0], w_ge2};
        if (r_cnt != CW'(FRAC_BITS - 1)) r_cnt <= r_cnt + CW'(1);
      end
      if (w_next == S_DONE) begin
        if (r_state == S_SPECIAL) begin
          r_result <= r_sp_res;
          r_inv    <= r_sp_inv;
          r_dbz    <= r_sp_dbz;
        end else begin
          r_result <= w_norm_res;
          r_inv    <= 1'b0;
          r_dbz    <= 1'b0;
        end
      end
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_result    = r_result;
  assign bus.o_invalid   = r_inv;
  assign bus.o_divbyzero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_fp_log2_seq.sv
//------------------------------------------------------------------------------
// tb_fp_log2_seq : scoreboard bench for fp_log2_seq (directed, specials,
//                  held-start handshake, mid-operation reset)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_log2_seq;

  localparam int FB = 23;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_log2_seq_if bus ();

  fp_log2_seq #(.FRAC_BITS(FB), .MW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    int          tol;
    logic        inv;
    logic        dbz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        plan[$];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input int tol = 0);
    longint d;
    n_cmp++;
    d = longint'(obs) - longint'(exp);
    if (d < 0) d = -d;
    if ($isunknown(obs) || d > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  // Truncating real -> FP32 conversion; er returns floor(log2|r|)
  function automatic logic [31:0] real2fp(input real r, output int er);
    real a;
    int  mant;
    a  = (r < 0.0) ? -r : r;
    er = 0;
    while (a >= 2.0) begin a = a / 2.0; er++; end
    while (a < 1.0)  begin a = a * 2.0; er--; end
    mant = $rtoi((a - 1.0) * 8388608.0);
    return {(r < 0.0), 8'(er + 127), 23'(mant)};
  endfunction

  function automatic exp_t mk(input logic [31:0] op, input logic [31:0] res,
                              input logic inv, input logic dbz, input int lat);
    exp_t e;
    e.op = op; e.res = res; e.tol = 0; e.inv = inv; e.dbz = dbz; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  // Reference from real-valued log2; tolerance covers fraction truncation at 2^-FB
  function automatic exp_t model(input logic [31:0] op);
    exp_t e;
    real  r;
    int   er;
    int   k;
    if (op[30:23] == 8'hFF && op[22:0] != 23'd0)  e = mk(op, 32'h7FC00000, 1'b1, 1'b0, 2);
    else if (op[31] && op[30:0] != 31'd0)          e = mk(op, 32'h7FC00000, 1'b1, 1'b0, 2);
    else if (op[30:23] == 8'h00)                   e = mk(op, 32'hFF800000, 1'b0, 1'b1, 2);
    else if (op[30:23] == 8'hFF)                   e = mk(op, 32'h7F800000, 1'b0, 1'b0, 2);
    else begin
      r = real'(int'(op[30:23]) - 127) + $ln(1.0 + real'(op[22:0]) / 8388608.0) / $ln(2.0);
      e = mk(op, 32'h0, 1'b0, 1'b0, FB + 2);
      if (r != 0.0) begin
        e.res = real2fp(r, er);
        k = 23 - FB - er;
        if (k > 30) k = 30;
        e.tol = 2 + ((k >= 0) ? (1 << k) : 1);
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [7:0]  ex;
    logic [31:0] m;
    ex = 8'($urandom_range(1, 254));
    if (ex == 8'd126 || ex == 8'd127) ex = 8'd128;
    m = $urandom;
    return {1'b0, ex, m[22:0]};
  endfunction

  task automatic chk_outs_zero(input string tag);
    check_val({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check_val({tag, "_done"}, 32'(bus.o_done), 32'd0);
    check_val({tag, "_res"},  bus.o_result, 32'd0);
    check_val({tag, "_inv"},  32'(bus.o_invalid), 32'd0);
    check_val({tag, "_dbz"},  32'(bus.o_divbyzero), 32'd0);
  endtask

  // hold=1 keeps start high every cycle with junk operands between acceptances
  task automatic run_plan(input bit hold);
    int   free_at;
    exp_t e;
    free_at = cyc;
    while (plan.size() > 0) begin
      @(posedge clk); #1;
      if (cyc >= free_at) begin
        e    = plan.pop_front();
        e.t0 = cyc;
        sb.push_back(e);
        bus.i_start   = 1'b1;
        bus.i_operand = e.op;
        free_at = cyc + e.lat + 1 + (hold ? 0 : $urandom_range(0, 2));
      end else begin
        bus.i_start   = hold;
        bus.i_operand = $urandom;
      end
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check_val("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check_val("busy", 32'(bus.o_busy), 32'((sb.size() > 0) && (cyc > sb[0].t0)));
      if (bus.o_done) begin
        if (sb.size() == 0) begin
          check_val("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("result", bus.o_result, e.res, e.tol);
          check_val("invalid", 32'(bus.o_invalid), 32'(e.inv));
          check_val("divbyzero", 32'(bus.o_divbyzero), 32'(e.dbz));
          check_val("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
        last_res  = bus.o_result;
        have_last = 1'b1;
      end else if (have_last) begin
        check_val("res_hold", bus.o_result, last_res);
      end
    end
  end

  initial begin
    int t0;
    bus.i_start   = 1'b0;
    bus.i_operand = '0;
    repeat (3) @(posedge clk);
    #1 chk_outs_zero("rst");
    @(negedge clk) rst_n = 1'b1;

    // Start an operation and reset it in its fifth cycle
    @(posedge clk); #1;
    bus.i_start   = 1'b1;
    bus.i_operand = 32'h41000000;
    t0 = cyc;
    @(posedge clk); #1 bus.i_start = 1'b0;
    while (cyc < t0 + 4) @(posedge clk);
    #2 check_val("busy_pre_rst", 32'(bus.o_busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_val("no_done_after_rst", 32'(bus.o_done), 32'd0);
    end

    mon_en    = 1'b1;
    last_res  = 32'h0;
    have_last = 1'b1;

    // Directed values and specials, start pulsed
    plan.push_back(mk(32'h41000000, 32'h40400000, 1'b0, 1'b0, FB + 2));
    plan.push_back(mk(32'h3F800000, 32'h00000000, 1'b0, 1'b0, FB + 2));
    plan.push_back(mk(32'h3F000000, 32'hBF800000, 1'b0, 1'b0, FB + 2));
    plan.push_back(mk(32'h00800000, 32'hC2FC0000, 1'b0, 1'b0, FB + 2));
    plan.push_back(model(32'h40400000));
    plan.push_back(model(32'h3F400000));
    plan.push_back(mk(32'hC0000000, 32'h7FC00000, 1'b1, 1'b0, 2));
    plan.push_back(mk(32'h7FC00001, 32'h7FC00000, 1'b1, 1'b0, 2));
    plan.push_back(mk(32'h00000000, 32'hFF800000, 1'b0, 1'b1, 2));
    plan.push_back(mk(32'h00000001, 32'hFF800000, 1'b0, 1'b1, 2));
    plan.push_back(mk(32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 2));
    plan.push_back(mk(32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 2));
    plan.push_back(mk(32'h80000000, 32'hFF800000, 1'b0, 1'b1, 2));
    plan.push_back(mk(32'h41000000, 32'h40400000, 1'b0, 1'b0, FB + 2));
    run_plan(1'b0);
    drain();

    // start held high, operand churning every cycle
    for (int i = 0; i < 8; i++) plan.push_back(model(rand_normal()));
    plan.push_back(model(32'hC1200000));
    plan.push_back(model(32'h3F400000));
    plan.push_back(model(32'h00000000));
    plan.push_back(model(rand_normal()));
    run_plan(1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
